// File: rtl/f_fetch_unit.sv
// Fetch stage: drives the instruction memory and fills the F/D register.
// It buffers one word when the fetch completes while the hazard unit stalls D.
module f_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] D_NPC,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic        D_exc_adel,
  output logic        fetch_busy
);

  typedef enum logic {FETCH, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dpc_q, dpc_d;
  logic [31:0] dinstr_q, dinstr_d;
  logic        dvalid_q, dvalid_d;
  logic        dexc_q, dexc_d;
  logic [31:0] buf_word_q, buf_word_d;
  logic        buf_exc_q, buf_exc_d;

  logic        legal;
  logic        avail;
  logic [31:0] word;
  logic        exc;

  assign legal = (pc_q[1:0] == 2'b00)
              && (pc_q >= IM_BASE)
              && (pc_q <= IM_LIMIT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dpc_d      = dpc_q;
    dinstr_d   = dinstr_q;
    dvalid_d   = dvalid_q;
    dexc_d     = dexc_q;
    buf_word_d = buf_word_q;
    buf_exc_d  = buf_exc_q;
    im_req     = 1'b0;
    fetch_busy = 1'b0;
    avail      = 1'b0;
    word       = 32'h0;
    exc        = 1'b0;

    unique case (state_q)
      FETCH: begin
        im_req     = legal;
        fetch_busy = legal && !im_ready;
        // Illegal PCs complete at once with a zero word and no request.
        if (!legal) begin
          avail = 1'b1;
          exc   = 1'b1;
        end else if (im_ready) begin
          avail = 1'b1;
          word  = im_rdata;
        end
      end
      HOLD: begin
        avail = 1'b1;
        word  = buf_word_q;
        exc   = buf_exc_q;
      end
    endcase

    if (avail && !stall) begin
      dpc_d    = pc_q;
      dinstr_d = word;
      dexc_d   = exc;
      dvalid_d = 1'b1;
      pc_d     = D_NPC;
      state_d  = FETCH;
    end else if (avail && state_q == FETCH) begin
      buf_word_d = word;
      buf_exc_d  = exc;
      state_d    = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= PC_RESET;
      dpc_q      <= 32'h0;
      dinstr_q   <= 32'h0;
      dvalid_q   <= 1'b0;
      dexc_q     <= 1'b0;
      buf_word_q <= 32'h0;
      buf_exc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dpc_q      <= dpc_d;
      dinstr_q   <= dinstr_d;
      dvalid_q   <= dvalid_d;
      dexc_q     <= dexc_d;
      buf_word_q <= buf_word_d;
      buf_exc_q  <= buf_exc_d;
    end
  end

  assign im_addr    = pc_q;
  assign F_PC       = pc_q;
  assign D_PC       = dpc_q;
  assign D_instr    = dinstr_q;
  assign D_valid    = dvalid_q;
  assign D_exc_adel = dexc_q;

endmodule
